// File: rtl/uartms_pkg.sv
// ----------------------------------------------------------------------------
// uartms_pkg
// Shared definitions for the uartms receive and transmit paths. It holds the
// receive FSM state type, the oversampling phase constants and the parity mode
// encoding.
// ----------------------------------------------------------------------------
package uartms_pkg;

    // Receive FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Oversampling phase at which the start bit is checked (its middle).
    localparam logic [3:0] OVS_MID  = 4'd7;
    // Phase at which data, parity and stop bits are sampled (one bit later).
    localparam logic [3:0] OVS_LAST = 4'd15;

    // Parity mode as seen on cfg_pri_mod.
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_t;

endpackage

// File: rtl/uartms_baud_tick.sv
// ----------------------------------------------------------------------------
// uartms_baud_tick
// Programmable 16x oversampling tick generator. The tick period is
// divisor+1 mclk cycles, so a divisor of 0 gives a tick on every cycle.
// The counter is held at 0 while disabled and can be cleared to realign its
// phase (the receiver does this on the start-bit edge).
//
// Ports:
//   mclk     in   system clock
//   reset_n  in   synchronous active-low reset
//   enable   in   count enable; 0 holds the counter at 0 and gives no ticks
//   clear    in   synchronous phase clear
//   divisor  in   tick period minus 1, in mclk cycles
//   tick     out  one-cycle tick when the counter reaches divisor
// ----------------------------------------------------------------------------
module uartms_baud_tick #(
    parameter int DIV_W = 12
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    // A divisor lowered below the current count is picked up after the
    // counter wraps, so the generator can never stall permanently.
    assign tick = enable && (div_cnt == divisor);

    // NOTE: the reset is sampled inside the clocked block, so it is
    // synchronous; no reset term appears in the sensitivity list.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (!enable || clear || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uartms_rx_core.sv
// ----------------------------------------------------------------------------
// uartms_rx_core
// UART receive engine: synchronises rxd, detects the start edge, oversamples
// at 16x and de-serialises start / DATA_W data bits (LSB first) / optional
// parity / stop. Completed bytes land in a single-entry valid/ready holding
// register; framing, parity and overrun problems are flagged as 1-cycle pulses.
//
// Ports:
//   mclk          in   system clock
//   reset_n       in   synchronous active-low reset
//   cfg_rx_enb    in   receiver enable; dropping it aborts a frame in flight
//   cfg_baud_16x  in   oversampling tick period minus 1
//   cfg_pri_en    in   parity bit present
//   cfg_pri_mod   in   0 = even, 1 = odd parity
//   rxd           in   asynchronous serial input
//   rx_data       out  received byte, stable while rx_valid is high
//   rx_valid      out  rx_data holds an unread byte
//   rx_ready      in   consumer accepts rx_data
//   rx_frm_err    out  pulse: stop bit sampled 0
//   rx_par_err    out  pulse: parity mismatch
//   rx_ovr_err    out  pulse: frame dropped because the holding reg was full
//   rx_busy       out  FSM not idle
// ----------------------------------------------------------------------------
module uartms_rx_core
    import uartms_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 12
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              cfg_rx_enb,
    input  logic [DIV_W-1:0]  cfg_baud_16x,
    input  logic              cfg_pri_en,
    input  logic              cfg_pri_mod,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frm_err,
    output logic              rx_par_err,
    output logic              rx_ovr_err,
    output logic              rx_busy
);

    localparam int OVS_W = $clog2(OVS);
    localparam int BIT_W = $clog2(DATA_W);

    logic              rxd_meta;
    logic              rxd_sync;
    logic              rxd_prev;
    logic              nedge;
    logic              start_det;
    logic              tick;
    logic              ovs_hit;
    logic              par_exp;
    logic              par_bad;

    rx_state_t         state;
    logic [OVS_W-1:0]  ovs_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    // Two-flop synchroniser plus one history flop for edge detection. The
    // idle line level is 1, so everything resets high.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Edge-only detection: a line held low (break) cannot retrigger a frame.
    assign nedge     = rxd_prev & ~rxd_sync;
    // Only a start edge seen from idle realigns the oversampling phase.
    assign start_det = cfg_rx_enb && nedge && (state == ST_IDLE);

    uartms_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .mclk    (mclk),
        .reset_n (reset_n),
        .enable  (cfg_rx_enb),
        .clear   (start_det),
        .divisor (cfg_baud_16x),
        .tick    (tick)
    );

    // The start bit is judged half a bit in; every later bit is sampled one
    // full bit after the previous sample, i.e. at its own middle.
    assign ovs_hit = (state == ST_START) ? (ovs_cnt == OVS_W'(OVS_MID))
                                         : (ovs_cnt == OVS_W'(OVS_LAST));

    assign par_exp = (^shreg) ^ (par_mode_t'(cfg_pri_mod) == PAR_ODD);
    assign par_bad = cfg_pri_en && (par_bit != par_exp);
    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ovs_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_frm_err <= 1'b0;
            rx_par_err <= 1'b0;
            rx_ovr_err <= 1'b0;
        end else begin
            rx_frm_err <= 1'b0;
            rx_par_err <= 1'b0;
            rx_ovr_err <= 1'b0;

            // NOTE: with non-blocking assignments the last one in the block
            // wins, so a frame completing in this same cycle overrides this
            // consume with rx_valid <= 1 further down.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (!cfg_rx_enb) begin
                // Abort: partial frame is discarded, holding reg untouched.
                state   <= ST_IDLE;
                ovs_cnt <= '0;
                bit_cnt <= '0;
            end else if (state == ST_IDLE) begin
                if (nedge) begin
                    state   <= ST_START;
                    ovs_cnt <= '0;
                end
            end else if (tick) begin
                if (!ovs_hit) begin
                    ovs_cnt <= ovs_cnt + OVS_W'(1);
                end else begin
                    ovs_cnt <= '0;
                    case (state)
                        ST_START: begin
                            bit_cnt <= '0;
                            // High at mid-start means a glitch, not a frame.
                            state   <= rxd_sync ? ST_IDLE : ST_DATA;
                        end
                        ST_DATA: begin
                            shreg   <= {rxd_sync, shreg[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                                state <= cfg_pri_en ? ST_PARITY : ST_STOP;
                            end
                        end
                        ST_PARITY: begin
                            par_bit <= rxd_sync;
                            state   <= ST_STOP;
                        end
                        ST_STOP: begin
                            state      <= ST_IDLE;
                            rx_frm_err <= ~rxd_sync;
                            rx_par_err <= par_bad;
                            // Bytes are delivered even with errors flagged.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_ovr_err <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uartms_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uartms_rx_core
// Self-checking bench for uartms_rx_core. Frames are driven onto rxd at the
// nominal bit rate; a negedge monitor records every byte delivery and counts
// the cycles each error pulse is high. Expected bytes and error flags come
// from a frame-level model (bit counts and parity arithmetic).
// ----------------------------------------------------------------------------
module tb_uartms_rx_core;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        cfg_rx_enb;
    logic [11:0] cfg_baud_16x;
    logic        cfg_pri_en;
    logic        cfg_pri_mod;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_frm_err;
    logic        rx_par_err;
    logic        rx_ovr_err;
    logic        rx_busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int start_cyc    = 0;

    // Monitor state.
    logic [7:0] got_q[$];
    int         got_t[$];
    int         frm_cnt;
    int         par_cnt;
    int         ovr_cnt;
    bit         busy_seen;
    logic       v_prev = 1'b0;
    logic       r_prev = 1'b0;

    uartms_rx_core dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_rx_enb   (cfg_rx_enb),
        .cfg_baud_16x (cfg_baud_16x),
        .cfg_pri_en   (cfg_pri_en),
        .cfg_pri_mod  (cfg_pri_mod),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frm_err   (rx_frm_err),
        .rx_par_err   (rx_par_err),
        .rx_ovr_err   (rx_ovr_err),
        .rx_busy      (rx_busy)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc++;

    // A new byte appears when rx_valid is high and either it was low before
    // or the previous byte was accepted on the edge in between.
    always @(negedge mclk) begin
        if (rx_frm_err) frm_cnt++;
        if (rx_par_err) par_cnt++;
        if (rx_ovr_err) ovr_cnt++;
        if (rx_busy) busy_seen = 1'b1;
        if (rx_valid && (!v_prev || r_prev)) begin
            got_q.push_back(rx_data);
            got_t.push_back(cyc);
        end
        v_prev = rx_valid;
        r_prev = rx_ready;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<1500000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- frame-level reference model ----------------
    // Parity error when the total count of ones (data + parity bit) does not
    // have the parity selected by the mode (even=0, odd=1).
    function automatic bit model_par_err(input logic [7:0] d, input bit pen,
                                         input bit pmod, input bit pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        return pen && ((ones % 2) != int'(pmod));
    endfunction

    function automatic int bit_clks(input int baud);
        return 16 * (baud + 1);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic b, input int n);
        @(posedge mclk);
        #1 rxd = b;
        repeat (n - 1) @(posedge mclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input bit stopb, input int n);
        @(posedge mclk);
        #1 rxd = 1'b0;
        start_cyc = cyc;
        repeat (n - 1) @(posedge mclk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        if (pen) drive_bit(pbit, n);
        drive_bit(stopb, n);
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_t.delete();
        frm_cnt   = 0;
        par_cnt   = 0;
        ovr_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic flush();
        @(posedge mclk);
        #1 rx_ready = 1'b1;
        repeat (2) @(posedge mclk);
        #1 rx_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        tests_run++;
        if ({rx_valid, rx_busy, rx_frm_err, rx_par_err, rx_ovr_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 00000",
                     {rx_valid, rx_busy, rx_frm_err, rx_par_err, rx_ovr_err});
        end
        tests_run++;
        if (rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: got %h required 00", rx_data);
        end
        reset_n = 1'b1;
        repeat (10) @(posedge mclk);
        #1;
        tests_run++;
        if ({rx_valid, rx_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got valid/busy %b required 00", {rx_valid, rx_busy});
        end
    endtask

    task automatic test_basic();
        int lat;
        cfg_baud_16x = 12'd3;
        cfg_pri_en   = 1'b0;
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        #1;
        tests_run++;
        if (got_q.size() !== 1 || rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_byte: got %0d bytes data=%h valid=%b required 1 byte data=a5 valid=1",
                     got_q.size(), rx_data, rx_valid);
        end
        lat = (got_t.size() > 0) ? got_t[0] - start_cyc : -1;
        tests_run++;
        if (lat < 576 || lat > 640) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles required 576..640 (about 9.5 bits)", lat);
        end
        tests_run++;
        if (frm_cnt + par_cnt + ovr_cnt !== 0) begin
            tests_failed++;
            $display("FAIL basic_errs: got frm=%0d par=%0d ovr=%0d required all 0", frm_cnt, par_cnt, ovr_cnt);
        end
        rx_ready = 1'b1;
        @(posedge mclk);
        #1 rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_consume: got valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_parity();
        cfg_pri_en  = 1'b1;
        cfg_pri_mod = 1'b1;
        rx_ready    = 1'b1;
        clear_mon();
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        tests_run++;
        if (got_q.size() !== 1 || par_cnt !== 0 || frm_cnt !== 0) begin
            tests_failed++;
            $display("FAIL parity_good: got %0d bytes par=%0d frm=%0d required 1 byte par=0 frm=0",
                     got_q.size(), par_cnt, frm_cnt);
        end
        clear_mon();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        tests_run++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'h03) || par_cnt !== 1) begin
            tests_failed++;
            $display("FAIL parity_bad: got %0d bytes par_pulse_cycles=%0d required 1 byte 03 and 1",
                     got_q.size(), par_cnt);
        end
        cfg_pri_en  = 1'b0;
        cfg_pri_mod = 1'b0;
    endtask

    task automatic test_break();
        rx_ready = 1'b1;
        clear_mon();
        drive_bit(1'b0, 22 * bit_clks(3));
        drive_bit(1'b1, 3 * bit_clks(3));
        #1;
        tests_run++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'h00) || frm_cnt !== 1) begin
            tests_failed++;
            $display("FAIL break_frame: got %0d bytes frm_pulse_cycles=%0d required 1 byte 00 and 1",
                     got_q.size(), frm_cnt);
        end
        tests_run++;
        if (rx_busy !== 1'b0 || par_cnt !== 0) begin
            tests_failed++;
            $display("FAIL break_no_retrigger: got busy=%b par=%0d required 0 0", rx_busy, par_cnt);
        end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        tests_run++;
        if (got_q.size() !== 2 || (got_q.size() == 2 && got_q[1] !== 8'h3C)) begin
            tests_failed++;
            $display("FAIL break_recover: got %0d bytes required 2 with last 3c", got_q.size());
        end
    endtask

    task automatic test_glitch();
        rx_ready = 1'b0;
        clear_mon();
        @(posedge mclk);
        #1 rxd = 1'b0;
        repeat (3) @(posedge mclk);
        #1 rxd = 1'b1;
        repeat (100) @(posedge mclk);
        #1;
        tests_run++;
        if (busy_seen !== 1'b1 || rx_busy !== 1'b0 || rx_valid !== 1'b0 || got_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL glitch: got busy_seen=%b busy=%b valid=%b bytes=%0d required 1 0 0 0",
                     busy_seen, rx_busy, rx_valid, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, bit_clks(3));
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        #1;
        tests_run++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1 || got_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL overrun_keep: got data=%h valid=%b bytes=%0d required 11 1 1",
                     rx_data, rx_valid, got_q.size());
        end
        tests_run++;
        if (ovr_cnt !== 1 || frm_cnt !== 0) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got ovr_cycles=%0d frm=%0d required 1 0", ovr_cnt, frm_cnt);
        end
        flush();
        clear_mon();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, bit_clks(3));
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b1, bit_clks(3));
            begin
                // Aim the one-cycle accept at the second frame's completion.
                repeat (611) @(posedge mclk);
                #1 rx_ready = 1'b1;
                @(posedge mclk);
                #1 rx_ready = 1'b0;
            end
        join
        drive_bit(1'b1, bit_clks(3));
        #1;
        tests_run++;
        if (rx_data !== 8'h22 || ovr_cnt !== 0 || got_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL accept_at_completion: got data=%h ovr=%0d bytes=%0d required 22 0 2",
                     rx_data, ovr_cnt, got_q.size());
        end
        flush();
    endtask

    task automatic test_enable_drop();
        rx_ready = 1'b1;
        clear_mon();
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b1, bit_clks(3));
            begin
                repeat (5 * 64 + 32) @(posedge mclk);
                #1 cfg_rx_enb = 1'b0;
                repeat (2) @(posedge mclk);
                #1;
                tests_run++;
                if (rx_busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL enable_drop_idle: got busy=%b required 0", rx_busy);
                end
            end
        join
        drive_bit(1'b1, bit_clks(3));
        cfg_rx_enb = 1'b1;
        drive_bit(1'b1, bit_clks(3));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        tests_run++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'h5A) ||
            frm_cnt + par_cnt + ovr_cnt !== 0) begin
            tests_failed++;
            $display("FAIL enable_drop_resume: got %0d bytes errs=%0d required 1 byte 5a, 0 errs",
                     got_q.size(), frm_cnt + par_cnt + ovr_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit         pen, pmod, pbit, stopb;
        int         baud;
        bit         exp_par;
        rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d     = 8'($urandom);
            pen   = 1'($urandom);
            pmod  = 1'($urandom);
            pbit  = 1'($urandom);
            stopb = ($urandom_range(3) != 0);
            baud  = $urandom_range(3);
            cfg_baud_16x = 12'(baud);
            cfg_pri_en   = pen;
            cfg_pri_mod  = pmod;
            exp_par      = model_par_err(d, pen, pmod, pbit);
            clear_mon();
            send_frame(d, pen, pbit, stopb, bit_clks(baud));
            drive_bit(1'b1, bit_clks(baud));
            tests_run++;
            if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== d) ||
                frm_cnt !== int'(!stopb) || par_cnt !== int'(exp_par) || ovr_cnt !== 0) begin
                tests_failed++;
                $display("FAIL random_frame %0d: got bytes=%0d data=%h frm=%0d par=%0d ovr=%0d required 1 %h %0d %0d 0",
                         i, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, frm_cnt, par_cnt,
                         ovr_cnt, d, int'(!stopb), int'(exp_par));
            end
        end
        cfg_baud_16x = 12'd3;
        cfg_pri_en   = 1'b0;
        cfg_pri_mod  = 1'b0;
    endtask

    task automatic test_reset_midframe();
        rx_ready = 1'b0;
        flush();
        clear_mon();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        drive_bit(1'b0, bit_clks(3));
        drive_bit(1'b1, bit_clks(3));
        drive_bit(1'b0, bit_clks(3) / 2);
        #1;
        tests_run++;
        if (rx_busy !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got busy=%b valid=%b data=%h required 1 1 c3",
                     rx_busy, rx_valid, rx_data);
        end
        reset_n = 1'b0;
        rxd     = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        tests_run++;
        if (rx_data !== 8'h00 ||
            {rx_valid, rx_busy, rx_frm_err, rx_par_err, rx_ovr_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_midframe: got data=%h flags=%b required 00 00000", rx_data,
                     {rx_valid, rx_busy, rx_frm_err, rx_par_err, rx_ovr_err});
        end
        reset_n = 1'b1;
        repeat (2 * bit_clks(3)) @(posedge mclk);
        #1;
        tests_run++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset_idle: got busy=%b valid=%b required 0 0", rx_busy, rx_valid);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        cfg_rx_enb   = 1'b1;
        cfg_baud_16x = 12'd3;
        cfg_pri_en   = 1'b0;
        cfg_pri_mod  = 1'b0;
        rxd          = 1'b1;
        rx_ready     = 1'b0;
        clear_mon();

        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_enable_drop();
        test_random();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uartms_rx_core.md
Name: uartms_rx_core

Overview:
UART receive engine for the uartms block. It consumes the 12-bit baud_16x divisor, either auto-detected or from a register, plus the rx enable. It generates its own 16x oversampling tick, then de-serialises rxd frames: start, 8 data bits LSB-first, optional parity, and stop. Received bytes go to a single-entry valid/ready holding register read by the register/FIFO interface, with per-frame error pulses.

Parameters:
DATA_W, 8, data bits per frame
OVS, 16, oversampling ticks per bit
DIV_W, 12, width of baud divisor

Ports:
mclk  input  1  system clock
reset_n  input  1  reset; synchronous, active-low
cfg_rx_enb  input  1  receiver enable (auto_rx_enb or register)
cfg_baud_16x  input  DIV_W  tick period minus 1, in mclk cycles
cfg_pri_en  input  1  parity bit present
cfg_pri_mod  input  1  0 = even, 1 = odd parity
rxd  input  1  asynchronous serial input
rx_data  output  DATA_W  received byte
rx_valid  output  1  rx_data holds an unread byte
rx_ready  input  1  consumer accepts rx_data
rx_frm_err  output  1  1-cycle pulse: stop bit sampled 0
rx_par_err  output  1  1-cycle pulse: parity mismatch
rx_ovr_err  output  1  1-cycle pulse: frame dropped, holding reg full
rx_busy  output  1  FSM not IDLE

Behaviour:
- Reset (reset_n low at a mclk edge): FSM IDLE, all counters 0, 2-flop rxd synchroniser = 1, rx_data = 0, rx_valid/rx_busy/all err = 0.
- Tick generator: div_cnt increments each mclk while cfg_rx_enb=1.
  - When div_cnt == cfg_baud_16x: tick=1, div_cnt <= 0. Period = cfg_baud_16x+1 cycles; value 0 gives a tick every cycle.
  - cfg_rx_enb=0: div_cnt held 0, no ticks.
  - div_cnt is also cleared on start-edge detect, which aligns sampling phase.
- Edge detect uses synchronised rxd: nedge = prev 1, now 0. Level sample = sync output.
- FSM (ovs_cnt 4-bit, bit_cnt 3-bit; advance only on tick):
  - IDLE: on nedge && cfg_rx_enb -> START, ovs_cnt=0. Detection is edge-only, so a held-low line (break) does not retrigger.
  - START: on the tick where ovs_cnt==7 (mid-bit), if sample=0 -> DATA with ovs_cnt=0, bit_cnt=0; else -> IDLE (glitch rejected, no outputs).
  - DATA: on the tick where ovs_cnt==15, shift the sample into shreg MSB (LSB-first reception) and bit_cnt++. After bit 7 -> PARITY if cfg_pri_en, else STOP.
  - PARITY: on ovs_cnt==15, capture par_bit -> STOP. Expected parity = ^shreg ^ cfg_pri_mod (even: total ones including parity bit even).
  - STOP: on ovs_cnt==15, sample the stop bit, do frame completion (below), -> IDLE. Only one stop bit is checked; extra stop bits look like idle.
- Frame completion (same cycle as the stop sample):
  - rx_frm_err = ~sample.
  - rx_par_err = cfg_pri_en && par mismatch.
  - The byte is delivered even when an error flag is set.
  - If rx_valid=0, or rx_valid && rx_ready this cycle: rx_data <= shreg, rx_valid <= 1.
  - Else: byte dropped, rx_data unchanged, rx_ovr_err pulse. The frm/par pulses still fire.
- Handshake:
  - rx_valid && rx_ready with no completion -> rx_valid <= 0 next cycle.
  - rx_data is stable while rx_valid=1.
  - rx_ready while rx_valid=0 is ignored.
- cfg_rx_enb deasserted mid-frame: FSM -> IDLE next cycle, partial frame discarded, no error pulses, holding register untouched.
- cfg_baud_16x changed mid-frame: takes effect at the next div_cnt compare. Undefined frame outcome, but no lock-up.
- Latency: rx_valid rises 1 cycle after the mid-stop-bit tick.

Decomposition:
- Package uartms_pkg holds:
  - the rx state typedef (IDLE, START, DATA, PARITY, STOP, 3-bit);
  - OVS_MID=7 and OVS_LAST=15;
  - the parity mode constants.
- Sub-module uartms_baud_tick (div_cnt, enable, sync-clear, tick out); reused by the tx path.

Test Plan:
- cfg_baud_16x=3 (bit=64 clk), no parity, send 0xA5 -> rx_data=0xA5, rx_valid=1 ~9.5 bit times after start edge, no err pulses; rx_ready=1 -> rx_valid=0 next cycle.
- Odd parity, send 0x03 with parity bit 1 -> no err; same byte with parity bit 0 -> rx_data=0x03 plus a 1-cycle rx_par_err.
- Stop bit driven 0 (break, line held low for 2 frames) -> rx_data=0x00, rx_frm_err pulse once, no second frame until rxd returns high and falls again.
- 3-clock low glitch on idle line, cfg_baud_16x=3 -> returns to IDLE at mid-start, rx_valid stays 0.
- Two back-to-back frames 0x11, 0x22, rx_ready=0 -> rx_data stays 0x11, rx_ovr_err pulse at second stop. Repeat with rx_ready=1 at the completion cycle -> rx_data=0x22, no ovr.
- cfg_rx_enb dropped at data bit 4, then re-enabled and 0x5A sent -> only 0x5A delivered; reset_n low mid-frame -> all outputs 0, rx_busy=0.
